// File: rtl/display_scan_arbiter_if.sv
// Bundle of request, value, mask and display signals between the service
// blocks (master) and the display scan arbiter (slave).
interface display_scan_arbiter_if;
  logic [3:0]  req;
  logic [15:0] val_time;
  logic [15:0] val_s1;
  logic [15:0] val_s2;
  logic [15:0] val_s3;
  logic [15:0] val_s4;
  logic [3:0]  blink_s1;
  logic [3:0]  blink_s2;
  logic        alarm_ring;
  logic [6:0]  seg;
  logic [3:0]  anode;
  logic [5:0]  grant;
  logic        frame_done;

  // req/alarm_ring are level requests with no ready: the grant is the only
  // acknowledgement and it changes only on the frame_done cycle.
  modport master (
    output req, val_time, val_s1, val_s2, val_s3, val_s4,
    output blink_s1, blink_s2, alarm_ring,
    input  seg, anode, grant, frame_done
  );

  modport slave (
    input  req, val_time, val_s1, val_s2, val_s3, val_s4,
    input  blink_s1, blink_s2, alarm_ring,
    output seg, anode, grant, frame_done
  );
endinterface

// File: rtl/display_scan_arbiter.sv
// Time-multiplexes one 4-digit 7-segment display between time, four services
// and the alarm flash; optional macro LEADING_ZERO_BLANK_EN blanks a leading 0.
module display_scan_arbiter #(
  parameter int SCAN_DIV     = 4096,
  parameter int BLINK_FRAMES = 64
) (
  input logic                   clk,
  input logic                   reset,
  display_scan_arbiter_if.slave bus
);

  localparam int SCAN_W  = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);

  // Owner encoding equals the grant bit index so grant is a plain shift.
  typedef enum logic [2:0] {
    OWN_S4    = 3'd0,
    OWN_S3    = 3'd1,
    OWN_S2    = 3'd2,
    OWN_S1    = 3'd3,
    OWN_TIME  = 3'd4,
    OWN_ALARM = 3'd5
  } owner_e;

  owner_e             owner_q, owner_d;
  logic [SCAN_W-1:0]  scan_cnt_q, scan_cnt_d;
  logic [1:0]         digit_q, digit_d;
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               blink_phase_q, blink_phase_d;
  logic [6:0]         seg_q, seg_d;
  logic [3:0]         anode_q, anode_d;

  logic        slot_end;
  logic        frame_end;
  logic [15:0] sel_val;
  logic [3:0]  nib;
  logic [3:0]  dig_en;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  assign slot_end  = (scan_cnt_q == SCAN_LAST);
  assign frame_end = slot_end && (digit_q == 2'd3);

  // Scan and blink timing.
  always_comb begin
    scan_cnt_d    = scan_cnt_q;
    digit_d       = digit_q;
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    if (slot_end) begin
      scan_cnt_d = '0;
      digit_d    = digit_q + 2'd1;
    end else begin
      scan_cnt_d = scan_cnt_q + SCAN_W'(1);
    end
    if (frame_end) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BLINK_W'(1);
      end
    end
  end

  // Ownership only moves on the frame boundary, so a frame is never mixed.
  always_comb begin
    owner_d = owner_q;
    if (frame_end) begin
      if (bus.alarm_ring)  owner_d = OWN_ALARM;
      else if (bus.req[3]) owner_d = OWN_S1;
      else if (bus.req[2]) owner_d = OWN_S2;
      else if (bus.req[1]) owner_d = OWN_S3;
      else if (bus.req[0]) owner_d = OWN_S4;
      else                 owner_d = OWN_TIME;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      scan_cnt_q    <= '0;
      digit_q       <= 2'd0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      owner_q       <= OWN_TIME;
    end else begin
      scan_cnt_q    <= scan_cnt_d;
      digit_q       <= digit_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      owner_q       <= owner_d;
    end
  end

  // Output datapath: source select, nibble pick, decode and masking.
  always_comb begin
    sel_val = bus.val_time;
    case (owner_q)
      OWN_S1:  sel_val = bus.val_s1;
      OWN_S2:  sel_val = bus.val_s2;
      OWN_S3:  sel_val = bus.val_s3;
      OWN_S4:  sel_val = bus.val_s4;
      default: sel_val = bus.val_time;
    endcase
  end

  assign nib    = sel_val[{digit_q, 2'b00} +: 4];
  assign dig_en = ~(4'b0001 << digit_q);

  always_comb begin
    seg_d   = bcd_to_seg(nib);
    anode_d = dig_en;
    case (owner_q)
      OWN_ALARM: if (blink_phase_q) seg_d = 7'h00;
      OWN_S1:    if (blink_phase_q && bus.blink_s1[digit_q]) anode_d = 4'hF;
      OWN_S2:    if (blink_phase_q && bus.blink_s2[digit_q]) anode_d = 4'hF;
      default:   ;
    endcase
`ifdef LEADING_ZERO_BLANK_EN
    // Tens-of-minutes zero is suppressed for clock-like sources only.
    if ((digit_q == 2'd3) && (nib == 4'd0) &&
        ((owner_q == OWN_TIME) || (owner_q == OWN_S1) || (owner_q == OWN_S2)))
      anode_d = 4'hF;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      seg_q   <= 7'h7F;
      anode_q <= 4'hF;
    end else begin
      seg_q   <= seg_d;
      anode_q <= anode_d;
    end
  end

  assign bus.seg        = seg_q;
  assign bus.anode      = anode_q;
  assign bus.grant      = 6'b000001 << owner_q;
  assign bus.frame_done = frame_end;

endmodule
